key_mode_ctrl: RTL and testbench

- Parametrised successor to the single-key start-programming/reset logic in the CPU top.
- Debounces NUM_KEYS raw push-buttons and provides per-key debounced levels and press/release pulses.
- Runs a run/program/hold mode FSM that produces the CPU core reset and the UART programmer reset.
- Sits between the board buttons, the UART programmer (upg_done) and the CPU core reset input.

---
 rtl/key_mode_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_key_mode_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// Debounces NUM_KEYS push-buttons and runs the run/program/hold mode FSM that drives the CPU
// core reset and the UART programmer reset. Define PG_TIMEOUT_EN to build the PROG watchdog.
module key_mode_ctrl #(
    parameter int NUM_KEYS   = 5,
    parameter int DB_CYCLES  = 20000,
    parameter int CNT_W      = 15,
    parameter int PG_KEY     = 0,
    parameter int RST_KEY    = 1,
    parameter int RST_HOLD   = 16,
    parameter int PG_TIMEOUT = 100000000
) (
    input  logic                fpga_clk,
    input  logic                fpga_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                upg_done,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                cpu_rst,
    output logic                upg_rst,
    output logic [1:0]          mode,
    output logic                pg_timeout
);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_PROG = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    if (DB_CYCLES < 2 || CNT_W < 1 || ((DB_CYCLES - 1) >> CNT_W) != 0 ||
        RST_HOLD < 1 || PG_TIMEOUT < 1 || PG_KEY == RST_KEY ||
        PG_KEY < 0 || PG_KEY >= NUM_KEYS || RST_KEY < 0 || RST_KEY >= NUM_KEYS) begin : g_bad_params
        $error("key_mode_ctrl: invalid parameter combination");
    end

    logic [NUM_KEYS-1:0] key_meta;
    logic [NUM_KEYS-1:0] key_sync;
    logic [CNT_W-1:0]    db_cnt [NUM_KEYS];

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments let the second flop take the first flop's old value.
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            // NOTE: these counters are plain registers, not a RAM, so every entry gets reset.
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_sync[i] == key_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]      <= '0;
                    key_level[i]   <= key_sync[i];
                    key_press[i]   <= key_sync[i];
                    key_release[i] <= ~key_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detection runs in every state so a level already high at PROG entry is not an edge.
    logic done_meta;
    logic done_sync;
    logic done_prev;
    logic done_rise;

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            done_meta <= upg_done;
            done_sync <= done_meta;
            done_prev <= done_sync;
        end
    end

    assign done_rise = done_sync & ~done_prev;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              cpu_rst_nxt;
    logic              upg_rst_nxt;
    logic              rst_req;
    logic              pg_req;
    logic              timeout_hit;

    assign rst_req = key_press[RST_KEY];
    assign pg_req  = key_press[PG_KEY];
    assign mode    = state;

`ifdef PG_TIMEOUT_EN
    localparam int              PG_W    = (PG_TIMEOUT > 1) ? $clog2(PG_TIMEOUT) : 1;
    localparam logic [PG_W-1:0] PG_LAST = PG_W'(PG_TIMEOUT - 1);

    logic [PG_W-1:0] pg_cnt;
    logic            pg_timeout_nxt;

    // Held at zero outside PROG, so it always starts from zero on PROG entry.
    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            pg_cnt <= '0;
        end else if (state != ST_PROG) begin
            pg_cnt <= '0;
        end else begin
            pg_cnt <= pg_cnt + PG_W'(1);
        end
    end

    assign timeout_hit = (state == ST_PROG) && (pg_cnt == PG_LAST);
`else
    assign timeout_hit = 1'b0;
    assign pg_timeout  = 1'b0;
`endif

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            cpu_rst  <= 1'b1;
            upg_rst  <= 1'b1;
`ifdef PG_TIMEOUT_EN
            pg_timeout <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            cpu_rst  <= cpu_rst_nxt;
            upg_rst  <= upg_rst_nxt;
`ifdef PG_TIMEOUT_EN
            pg_timeout <= pg_timeout_nxt;
`endif
        end
    end

    // RST_KEY outranks PG_KEY and upg_done; the watchdog is the weakest PROG exit.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        unique case (state)
            ST_HOLD: begin
                if (rst_req) begin
                    hold_cnt_nxt = '0;
                end else if (pg_req) begin
                    state_nxt = ST_PROG;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (rst_req) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end else if (pg_req) begin
                    state_nxt = ST_PROG;
                end
            end
            ST_PROG: begin
                if (rst_req || done_rise || timeout_hit) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_HOLD;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        cpu_rst_nxt = (state_nxt != ST_RUN);
        upg_rst_nxt = (state_nxt != ST_PROG);
`ifdef PG_TIMEOUT_EN
        pg_timeout_nxt = pg_timeout;
        if (state != ST_PROG && state_nxt == ST_PROG) begin
            pg_timeout_nxt = 1'b0;
        end else if (state == ST_PROG && state_nxt == ST_HOLD && !rst_req && !done_rise) begin
            pg_timeout_nxt = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: reset/debounce vector table, directed mode sequences,
// then randomized key/upg_done traffic against a behavioural model.
module tb_key_mode_ctrl;

    localparam int NUM_KEYS   = 2;
    localparam int DB_CYCLES  = 4;
    localparam int CNT_W      = 2;
    localparam int PG_KEY     = 0;
    localparam int RST_KEY    = 1;
    localparam int RST_HOLD   = 3;
    localparam int PG_TIMEOUT = 50;
`ifdef PG_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [1:0] M_RUN  = 2'b00;
    localparam logic [1:0] M_PROG = 2'b01;
    localparam logic [1:0] M_HOLD = 2'b10;

    logic                fpga_clk;
    logic                fpga_rst;
    logic [NUM_KEYS-1:0] key_in;
    logic                upg_done;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                cpu_rst;
    logic                upg_rst;
    logic [1:0]          mode;
    logic                pg_timeout;

    key_mode_ctrl #(
        .NUM_KEYS  (NUM_KEYS),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .PG_KEY    (PG_KEY),
        .RST_KEY   (RST_KEY),
        .RST_HOLD  (RST_HOLD),
        .PG_TIMEOUT(PG_TIMEOUT)
    ) dut (
        .fpga_clk   (fpga_clk),
        .fpga_rst   (fpga_rst),
        .key_in     (key_in),
        .upg_done   (upg_done),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .cpu_rst    (cpu_rst),
        .upg_rst    (upg_rst),
        .mode       (mode),
        .pg_timeout (pg_timeout)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: a key is accepted once the synchronised samples (raw input two
    // edges late) have all disagreed with the accepted level for the last DB_CYCLES edges.
    logic [1:0] key_hist [$];
    logic       done_hist[$];
    logic [1:0] m_level, m_press, m_release, m_mode;
    int         m_hold_age, m_prog_age;
    logic       m_pgto;

    task automatic model_reset();
        key_hist  = {};
        done_hist = {};
        for (int i = 0; i < 8; i++) begin
            key_hist.push_back(2'b00);
            done_hist.push_back(1'b0);
        end
        m_level    = '0;
        m_press    = '0;
        m_release  = '0;
        m_mode     = M_HOLD;
        m_hold_age = 0;
        m_prog_age = 0;
        m_pgto     = 1'b0;
    endtask

    task automatic model_enter_prog();
        m_mode     = M_PROG;
        m_prog_age = 0;
        m_pgto     = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] k, input logic d);
        logic       rise;
        logic [1:0] nlevel;
        bit         stable;
        rise = done_hist[1] && !done_hist[2];
        case (m_mode)
            M_HOLD: begin
                if (m_press[RST_KEY]) m_hold_age = 0;
                else if (m_press[PG_KEY]) model_enter_prog();
                else if (m_hold_age == RST_HOLD - 1) m_mode = M_RUN;
                else m_hold_age++;
            end
            M_RUN: begin
                if (m_press[RST_KEY]) begin
                    m_mode     = M_HOLD;
                    m_hold_age = 0;
                end else if (m_press[PG_KEY]) begin
                    model_enter_prog();
                end
            end
            M_PROG: begin
                if (m_press[RST_KEY] || rise) begin
                    m_mode     = M_HOLD;
                    m_hold_age = 0;
                end else if (TIMEOUT_EN && m_prog_age == PG_TIMEOUT - 1) begin
                    m_mode     = M_HOLD;
                    m_hold_age = 0;
                    m_pgto     = 1'b1;
                end else begin
                    m_prog_age++;
                end
            end
            default: ;
        endcase
        nlevel = m_level;
        for (int b = 0; b < NUM_KEYS; b++) begin
            stable = 1'b1;
            for (int j = 1; j <= DB_CYCLES; j++) begin
                if (key_hist[j][b] == m_level[b]) stable = 1'b0;
            end
            if (stable) nlevel[b] = ~m_level[b];
        end
        m_press   = nlevel & ~m_level;
        m_release = ~nlevel & m_level;
        m_level   = nlevel;
        key_hist.push_front(k);
        void'(key_hist.pop_back());
        done_hist.push_front(d);
        void'(done_hist.pop_back());
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic tick(input logic [1:0] k, input logic d);
        key_in   = k;
        upg_done = d;
        model_step(k, d);
        @(posedge fpga_clk);
        @(negedge fpga_clk);
    endtask

    task automatic hold_inputs(input logic [1:0] k, input logic d, input int n);
        for (int i = 0; i < n; i++) tick(k, d);
    endtask

    task automatic compare_model(input int cyc);
        check($sformatf("model_cyc%0d", cyc),
              {21'd0, key_level, key_press, key_release, mode, cpu_rst, upg_rst, pg_timeout},
              {21'd0, m_level, m_press, m_release, m_mode, ~(m_mode == M_RUN), ~(m_mode == M_PROG), m_pgto});
    endtask

    typedef struct {
        logic [1:0] key;
        logic       done;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] md;
        logic       cpu;
        logic       upg;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vecs(input int n, input logic [1:0] k, input logic [1:0] lvl, input logic [1:0] prs,
                            input logic [1:0] rel, input logic [1:0] md, input logic cpu, input logic upg);
        for (int i = 0; i < n; i++) vecs.push_back('{k, 1'b0, lvl, prs, rel, md, cpu, upg});
    endtask

    initial begin
        int n;
        logic [1:0] rk;
        logic       rd;
        int         len;
        int         cyc;

        // Reset release, 3 HOLD cycles, glitch rejection, press into PROG, release pulse.
        add_vecs(2, 2'b00, 2'b00, 2'b00, 2'b00, M_HOLD, 1'b1, 1'b1);
        add_vecs(1, 2'b00, 2'b00, 2'b00, 2'b00, M_RUN,  1'b0, 1'b1);
        add_vecs(3, 2'b01, 2'b00, 2'b00, 2'b00, M_RUN,  1'b0, 1'b1);
        add_vecs(5, 2'b00, 2'b00, 2'b00, 2'b00, M_RUN,  1'b0, 1'b1);
        add_vecs(5, 2'b01, 2'b00, 2'b00, 2'b00, M_RUN,  1'b0, 1'b1);
        add_vecs(1, 2'b01, 2'b01, 2'b01, 2'b00, M_RUN,  1'b0, 1'b1);
        add_vecs(2, 2'b01, 2'b01, 2'b00, 2'b00, M_PROG, 1'b1, 1'b0);
        add_vecs(5, 2'b00, 2'b01, 2'b00, 2'b00, M_PROG, 1'b1, 1'b0);
        add_vecs(1, 2'b00, 2'b00, 2'b00, 2'b01, M_PROG, 1'b1, 1'b0);
        add_vecs(1, 2'b00, 2'b00, 2'b00, 2'b00, M_PROG, 1'b1, 1'b0);

        fpga_rst = 1'b0;
        key_in   = '0;
        upg_done = 1'b0;
        model_reset();
        repeat (2) @(negedge fpga_clk);
        check("rst_key_level",   key_level,   2'b00);
        check("rst_key_press",   key_press,   2'b00);
        check("rst_key_release", key_release, 2'b00);
        check("rst_mode",        mode,        M_HOLD);
        check("rst_cpu_rst",     cpu_rst,     1'b1);
        check("rst_upg_rst",     upg_rst,     1'b1);
        check("rst_pg_timeout",  pg_timeout,  1'b0);
        fpga_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].key, vecs[i].done);
            check($sformatf("vec%0d_level", i),   key_level,   vecs[i].lvl);
            check($sformatf("vec%0d_press", i),   key_press,   vecs[i].prs);
            check($sformatf("vec%0d_release", i), key_release, vecs[i].rel);
            check($sformatf("vec%0d_mode", i),    mode,        vecs[i].md);
            check($sformatf("vec%0d_cpu_rst", i), cpu_rst,     vecs[i].cpu);
            check($sformatf("vec%0d_upg_rst", i), upg_rst,     vecs[i].upg);
        end

        // upg_done rising in PROG: HOLD after the synchroniser delay, then RUN 3 cycles later.
        n = 0;
        do begin
            tick(2'b00, 1'b1);
            n++;
        end while (mode == M_PROG && n < 10);
        check("done_rise_latency", n, 3);
        check("done_rise_mode", mode, M_HOLD);
        check("done_rise_upg_rst", upg_rst, 1'b1);
        n = 0;
        do begin
            tick(2'b00, 1'b1);
            n++;
        end while (mode == M_HOLD && n < 10);
        check("hold_to_run_cycles", n, 3);
        check("hold_to_run_cpu_rst", cpu_rst, 1'b0);

        // upg_done already high when PROG is entered: no edge, stays in PROG.
        hold_inputs(2'b01, 1'b1, 7);
        check("prog_entry_mode", mode, M_PROG);
        hold_inputs(2'b00, 1'b1, 20);
        check("done_level_no_exit", mode, M_PROG);
        check("done_level_upg_rst", upg_rst, 1'b0);
        hold_inputs(2'b10, 1'b0, 7);
        check("prog_abort_mode", mode, M_HOLD);
        hold_inputs(2'b00, 1'b0, 8);
        check("abort_back_to_run", mode, M_RUN);

        // Both keys pressed on the same edge: reset wins.
        hold_inputs(2'b11, 1'b0, 7);
        check("dual_press_level", key_level, 2'b11);
        check("dual_press_mode", mode, M_HOLD);
        hold_inputs(2'b00, 1'b0, 10);
        check("dual_press_recover", mode, M_RUN);

`ifdef PG_TIMEOUT_EN
        hold_inputs(2'b01, 1'b0, 7);
        check("wd_prog_entry", mode, M_PROG);
        n = 0;
        do begin
            tick(2'b00, 1'b0);
            n++;
        end while (mode == M_PROG && n < 80);
        check("wd_cycles_in_prog", n, PG_TIMEOUT);
        check("wd_mode", mode, M_HOLD);
        check("wd_flag_set", pg_timeout, 1'b1);
        n = 0;
        do begin
            tick(2'b00, 1'b0);
            n++;
        end while (mode != M_RUN && n < 10);
        check("wd_back_to_run", mode, M_RUN);
        check("wd_flag_sticky", pg_timeout, 1'b1);
        hold_inputs(2'b01, 1'b0, 7);
        check("wd_reentry_mode", mode, M_PROG);
        check("wd_flag_cleared", pg_timeout, 1'b0);
        hold_inputs(2'b00, 1'b0, 8);
`else
        hold_inputs(2'b01, 1'b0, 7);
        check("nowd_prog_entry", mode, M_PROG);
        hold_inputs(2'b00, 1'b0, 60);
        check("nowd_still_prog", mode, M_PROG);
        check("nowd_flag_zero", pg_timeout, 1'b0);
`endif
        hold_inputs(2'b10, 1'b0, 7);
        check("leave_prog_mode", mode, M_HOLD);
        hold_inputs(2'b00, 1'b0, 8);
        check("leave_prog_run", mode, M_RUN);

        // Reset pulled mid-PROG forces the programmer idle without waiting for a clock.
        hold_inputs(2'b01, 1'b0, 7);
        check("midprog_entry", mode, M_PROG);
        #2;
        fpga_rst = 1'b0;
        key_in   = '0;
        model_reset();
        #1;
        check("midprog_rst_cpu_rst", cpu_rst, 1'b1);
        check("midprog_rst_upg_rst", upg_rst, 1'b1);
        check("midprog_rst_mode", mode, M_HOLD);
        check("midprog_rst_level", key_level, 2'b00);
        @(negedge fpga_clk);
        fpga_rst = 1'b1;

        // Randomized traffic against the model; the reset key is held less often.
        cyc = 0;
        for (int seg = 0; seg < 400; seg++) begin
            rk[0] = 1'($urandom_range(0, 1));
            rk[1] = ($urandom_range(0, 3) == 0);
            rd    = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                tick(rk, rd);
                compare_model(cyc);
                cyc++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
